// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline encodings and widths
package mips_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Writeback source select
  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  // Destination register select
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - 8-bit wait counter with clear/enable and terminal count
module mem_timeout_ctr #(
  parameter logic [7:0] TC = 8'd15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM stage: data bus access, stall, MEM/WB register
module mem_stage_unit
  import mips_pipe_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_plus4,
  input  logic              MemWr,
  input  logic              MemRd,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] DataBus_B,
  input  logic [1:0]        RegDst,
  input  logic              RegWr,
  input  logic [1:0]        MemToReg,
  input  logic [REG_AW-1:0] RegisterRd,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic [DATA_W-1:0] PC_plus4_out,
  output logic [DATA_W-1:0] ALUOut_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [1:0]        RegDst_out,
  output logic [1:0]        MemToReg_out,
  output logic              RegWr_out,
  output logic [REG_AW-1:0] RegisterRd_out
);

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e state, state_nxt;
  logic mem_op, aligned, misaligned;
  logic ctr_clr, ctr_en, ctr_tc;
  logic timeout_now, timed_out, acked;

  assign mem_op     = MemRd | MemWr;
  assign aligned    = (ALUOut[1:0] == 2'b00);
  assign misaligned = (state == ST_IDLE) & mem_op & ~aligned;

  assign bus_we    = MemWr;
  assign bus_addr  = ALUOut;
  assign bus_wdata = DataBus_B;

  mem_timeout_ctr #(.TC(TC_LAST)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        bus_req = mem_op & aligned;
        if (bus_req & ~bus_ack) begin
          state_nxt = ST_WAIT;
          ctr_clr   = 1'b1;
        end
      end
      ST_WAIT: begin
        bus_req = 1'b1;
        ctr_en  = 1'b1;
        if (bus_ack | ctr_tc) state_nxt = ST_IDLE;
      end
    endcase
  end

  // An ack arriving on the terminal cycle still counts as a completed access
  assign timeout_now = (state == ST_WAIT) & ctr_tc;
  assign timed_out   = timeout_now & ~bus_ack;
  assign acked       = bus_req & bus_ack;
  assign stall       = bus_req & ~bus_ack & ~timeout_now;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_err       <= 1'b0;
      bus_err        <= 1'b0;
      PC_plus4_out   <= '0;
      ALUOut_out     <= '0;
      ReadData_out   <= '0;
      RegDst_out     <= RDST_RT;
      MemToReg_out   <= MTR_ALU;
      RegWr_out      <= 1'b0;
      RegisterRd_out <= '0;
    end else begin
      addr_err <= misaligned;
      bus_err  <= timed_out;
      if (stall) begin
        // Bubble: the instruction is still in flight, so nothing may retire
        RegWr_out    <= 1'b0;
        MemToReg_out <= MTR_ALU;
      end else begin
        PC_plus4_out   <= PC_plus4;
        ALUOut_out     <= ALUOut;
        RegDst_out     <= RegDst;
        MemToReg_out   <= MemToReg;
        RegisterRd_out <= RegisterRd;
        if (misaligned)     RegWr_out <= 1'b0;
        else if (timed_out) RegWr_out <= RegWr & ~MemRd;
        else                RegWr_out <= RegWr;
        if (acked & ~MemWr)          ReadData_out <= bus_rdata;
        else if (timed_out & ~MemWr) ReadData_out <= ERR_RDATA;
        else                         ReadData_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - randomized self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_plus4, ALUOut, DataBus_B, bus_rdata;
  logic        MemWr, MemRd, RegWr, bus_ack;
  logic [1:0]  RegDst, MemToReg;
  logic [5:0]  RegisterRd;
  logic        bus_req, bus_we, stall, addr_err, bus_err;
  logic [31:0] bus_addr, bus_wdata, PC_plus4_out, ALUOut_out, ReadData_out;
  logic [1:0]  RegDst_out, MemToReg_out;
  logic        RegWr_out;
  logic [5:0]  RegisterRd_out;

  int total = 0;
  int bad   = 0;

  mem_stage_unit #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset), .PC_plus4(PC_plus4), .MemWr(MemWr), .MemRd(MemRd),
    .ALUOut(ALUOut), .DataBus_B(DataBus_B), .RegDst(RegDst), .RegWr(RegWr),
    .MemToReg(MemToReg), .RegisterRd(RegisterRd), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .addr_err(addr_err), .bus_err(bus_err), .PC_plus4_out(PC_plus4_out),
    .ALUOut_out(ALUOut_out), .ReadData_out(ReadData_out), .RegDst_out(RegDst_out),
    .MemToReg_out(MemToReg_out), .RegWr_out(RegWr_out), .RegisterRd_out(RegisterRd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, rw;
    logic [31:0] pc4, addr, wd, rdata;
    logic [1:0]  rdst, mtr;
    logic [5:0]  rreg;
    int          lat;
  } instr_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply(input instr_t i);
    MemRd = i.rd; MemWr = i.wr; RegWr = i.rw; PC_plus4 = i.pc4; ALUOut = i.addr;
    DataBus_B = i.wd; RegDst = i.rdst; MemToReg = i.mtr; RegisterRd = i.rreg;
  endtask

  function automatic instr_t mk(input logic rd, input logic wr, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int lat);
    instr_t i;
    i.rd = rd; i.wr = wr; i.rw = rw; i.addr = addr; i.wd = wd; i.rdata = rdata; i.lat = lat;
    i.pc4 = $urandom; i.rdst = 2'($urandom_range(0, 2)); i.mtr = 2'($urandom_range(1, 2));
    i.rreg = 6'($urandom_range(1, 63));
    return i;
  endfunction

  // Reference: an aligned access stalls until acked or for T cycles, whichever comes first
  task automatic do_instr(input instr_t i);
    bit          access, mis, tout;
    int          nst, seen;
    logic        exp_rw;
    logic [31:0] exp_rd;
    mis    = (i.rd | i.wr) && (i.addr[1:0] != 2'b00);
    access = (i.rd | i.wr) && !mis;
    tout   = access && (i.lat > T);
    nst    = access ? ((i.lat < T) ? i.lat : T) : 0;
    apply(i);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      bus_ack   = access ? (k == i.lat) : 1'($urandom_range(0, 1));
      bus_rdata = (access && k == i.lat) ? i.rdata : $urandom;
      @(negedge clk);
      check("bus_req", 32'(bus_req), 32'(access));
      if (access) begin
        check("bus_we", 32'(bus_we), 32'(i.wr));
        check("bus_addr", bus_addr, i.addr);
        check("bus_wdata", bus_wdata, i.wd);
      end
      if (!stall) break;
      seen++;
      @(posedge clk); #1;
      check("bubble_regwr", 32'(RegWr_out), 32'd0);
      check("bubble_memtoreg", 32'(MemToReg_out), 32'd0);
    end
    check("stall_cycles", 32'(seen), 32'(nst));
    @(posedge clk); #1;
    bus_ack = 1'b0;
    exp_rw = mis ? 1'b0 : (tout ? (i.rw & ~i.rd) : i.rw);
    if (i.wr || !access) exp_rd = 32'd0;
    else                 exp_rd = tout ? ERR : i.rdata;
    check("regwr_out", 32'(RegWr_out), 32'(exp_rw));
    check("readdata_out", ReadData_out, exp_rd);
    check("pc4_out", PC_plus4_out, i.pc4);
    check("aluout_out", ALUOut_out, i.addr);
    check("regdst_out", 32'(RegDst_out), 32'(i.rdst));
    check("memtoreg_out", 32'(MemToReg_out), 32'(i.mtr));
    check("rd_out", 32'(RegisterRd_out), 32'(i.rreg));
    check("addr_err", 32'(addr_err), 32'(mis));
    check("bus_err", 32'(bus_err), 32'(tout));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_regwr"}, 32'(RegWr_out), 32'd0);
    check({tag, "_rdata"}, ReadData_out, 32'd0);
    check({tag, "_pc4"}, PC_plus4_out, 32'd0);
    check({tag, "_alu"}, ALUOut_out, 32'd0);
    check({tag, "_mtr"}, 32'(MemToReg_out), 32'd0);
    check({tag, "_rdst"}, 32'(RegDst_out), 32'd0);
    check({tag, "_rd"}, 32'(RegisterRd_out), 32'd0);
    check({tag, "_errs"}, {30'd0, addr_err, bus_err}, 32'd0);
    check({tag, "_busreq"}, 32'(bus_req), 32'd0);
  endtask

  task automatic reset_mid_wait();
    instr_t i, nop;
    i   = mk(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'd0, 32'd0, NEVER);
    nop = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 0);
    apply(i);
    bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    apply(nop);
    @(posedge clk); #1;
    reset = 1'b1;
    check_cleared("rst_mid");
    bus_ack = 1'b1; bus_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("late_ack_regwr", 32'(RegWr_out), 32'd0);
    check("late_ack_rdata", ReadData_out, 32'd0);
    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0084, 32'd0, 32'h0BAD_CAFE, 2));
  endtask

  function automatic instr_t rand_instr();
    int          op, lsel, lat;
    logic [31:0] a;
    op = $urandom_range(0, 3);
    a  = {16'd0, 14'($urandom), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    lsel = $urandom_range(0, 9);
    case (lsel)
      0:       lat = T - 1;
      1:       lat = T;
      2:       lat = T + 1;
      3:       lat = NEVER;
      default: lat = $urandom_range(0, 4);
    endcase
    return mk(op[0], op[1], 1'($urandom_range(0, 1)), a, $urandom, $urandom, lat);
  endfunction

  initial begin
    reset = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    apply(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b1;

    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 32'h1234_5678, 0));
    do_instr(mk(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 3));
    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'd0, 32'd0, 0));
    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'd0, 32'd0, NEVER));
    do_instr(mk(1'b0, 1'b0, 1'b1, 32'h0000_0034, 32'd0, 32'd0, 0));
    reset_mid_wait();
    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'd0, 32'h1111_2222, 1));
    do_instr(mk(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'd0, 32'h3333_4444, 1));
    do_instr(mk(1'b1, 1'b1, 1'b1, 32'h0000_0048, 32'h5555_6666, 32'd0, NEVER));

    for (int n = 0; n < 200; n++) do_instr(rand_instr());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
